fma_result_collector: RTL and testbench
=======================================

// Module: fma_result_collector
// PURPOSE
// - Result-side responder for the fpfma datapath: tracks which fpfma input cycles carried real operands and captures the matching fpfma.result words LAT cycles later.
// - Classifies each captured result and buffers it with its tag in a FIFO. The FIFO is drained through a valid/ready port by the writeback stage or the scoreboard.
// - Grants issue credits so the FIFO can never overflow.
// PARAMETERS
// - WIDTH  32  float width, 32 or 64 (exp/frac split 8/23 or 11/52)
// - LAT    3   fpfma latency, cycles from operands sampled to result valid, >=1
// - DEPTH  4   FIFO entries, power of 2, >=2
// - TAG_W  4   issue tag width
// PORTS
// - clk          in   1        rising-edge clock
// - rst          in   1        synchronous reset, active-high
// - issue_valid  in   1        operands A/B/C presented to fpfma this cycle
// - issue_tag    in   TAG_W    tag for that operation
// - issue_ready  out  1        credit available; issue accepted only if valid&ready
// - fma_result   in   WIDTH    fpfma.result
// - out_valid    out  1        FIFO head valid
// - out_ready    in   1        consumer accepts head
// - out_result   out  WIDTH    head result word
// - out_tag      out  TAG_W    head tag
// - out_class    out  3        0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
// - count        out  $clog2(DEPTH)+1  FIFO occupancy
// - proto_err    out  1        sticky: issue_valid while !issue_ready
// BEHAVIOUR
// - Reset: all outputs 0 except issue_ready=1. Pipe valids, FIFO pointers, count and proto_err are cleared.
// - A reset mid-operation discards all in-flight ops and all FIFO contents.
// - Tracking pipe: LAT-stage shift register of {v,tag}. Stage0 loads {issue_valid&issue_ready, issue_tag}.
// - Push: when stage LAT-1 v=1, on the same edge write {tag, fma_result, class(fma_result)} to the FIFO tail.
// - Pop: out_valid&&out_ready. Head advances on that edge.
// - Credits: inflight = number of set v bits in the pipe.
//   - issue_ready = (count + inflight) < DEPTH, combinational from registered state.
//   - An issue that is not accepted does not enter the pipe and sets proto_err.
// - Simultaneous push+pop, including when full or when count==1: count is unchanged, both pointers advance, and the data stays consistent.
// - Pop when empty is ignored. A push can never find the FIFO full, because of the credit scheme; an assertion checks this.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count saturates at neither end.
// - out_* are driven from the FIFO head registers. Data is stable while out_valid && !out_ready.
// - Classification: e = exponent field, f = fraction field. The qNaN test uses the f MSB.
//   - e==0 and f==0 -> zero; e==0 and f!=0 -> subnormal.
//   - e==all-ones and f==0 -> inf.
//   - e==all-ones, f!=0, f MSB=1 -> qNaN; f MSB=0 -> sNaN.
//   - otherwise -> normal. The sign bit is ignored.
// - End-to-end latency: issue edge -> out_valid high LAT+1 cycles later when the FIFO was empty.
// CONFIGURATION
// - FMA_COLLECT_STATS_EN defined:
//   - adds outputs nan_cnt[15:0] and inf_cnt[15:0].
//   - Each push of class 4 or 5 increments nan_cnt; each push of class 3 increments inf_cnt. Both saturate at 16'hFFFF.
//   - Both are cleared by rst.
// - FMA_COLLECT_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Single op: WIDTH=32, LAT=3, issue tag 5 with fma_result=32'h41200000 at the capture cycle -> out_valid 4 cycles later, out_tag=5, out_class=2.
// - Classes: capture 32'h00000000, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001 -> out_class 0, 1, 3, 4, 5 in order.
// - Credits: out_ready=0, issue every cycle -> exactly 4 accepted; issue_ready=0 after the 4th accepted issue; count reaches 4; no loss.
// - Full push+pop: FIFO full, out_ready=1 with issue continuing -> 1 pop and 1 push per cycle; count stays at 4; tags emerge in issue order.
// - Protocol: issue_valid=1 while issue_ready=0 -> proto_err=1 and stays set; that op never appears on the output. A later rst clears proto_err to 0.
// - Reset mid-flight: 2 ops in the pipe and 2 in the FIFO, then assert rst -> next cycle out_valid=0, count=0, issue_ready=1; the stale ops never appear.
// - Stats (FMA_COLLECT_STATS_EN): 3 NaN captures and 1 inf capture -> nan_cnt=3, inf_cnt=1.

Source files
------------

// File: rtl/fma_result_collector.sv
// Result-side collector for fpfma: tracks accepted issues for LAT cycles, captures and classifies results into a credit-protected FIFO.
// Optional NaN/inf push statistics are enabled by defining FMA_COLLECT_STATS_EN.
module fma_result_collector #(
    parameter int WIDTH = 32,
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [TAG_W-1:0]       issue_tag,
    output logic                   issue_ready,
    input  logic [WIDTH-1:0]       fma_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_class,
    output logic [$clog2(DEPTH):0] count,
`ifdef FMA_COLLECT_STATS_EN
    output logic [15:0]            nan_cnt,
    output logic [15:0]            inf_cnt,
`endif
    output logic                   proto_err
);
    localparam int EXP_W  = (WIDTH == 64) ? 11 : 8;
    localparam int FRAC_W = WIDTH - 1 - EXP_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] w);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e = w[WIDTH-2 -: EXP_W];
        f = w[FRAC_W-1:0];
        if (e == '0)      classify = (f == '0) ? 3'd0 : 3'd1;
        else if (e != '1) classify = 3'd2;
        else if (f == '0) classify = 3'd3;
        else              classify = f[FRAC_W-1] ? 3'd4 : 3'd5;
    endfunction

    logic             vld_p [LAT];
    logic [TAG_W-1:0] tag_p [LAT];
    int               inflight;

    // Tracking pipe: stage 0 holds operands sampled this edge, stage LAT-1 meets the result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= issue_valid & issue_ready;
            for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= issue_tag;
        for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
    end

    always_comb begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) inflight += int'(vld_p[i]);
    end

    // Every in-flight op already owns a FIFO slot, so a push can never meet a full FIFO
    assign issue_ready = (int'(count) + inflight) < DEPTH;

    logic [WIDTH-1:0] resMem [DEPTH];
    logic [TAG_W-1:0] tagMem [DEPTH];
    logic [2:0]       clsMem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             push;
    logic             pop;
    logic [2:0]       pushCls;

    assign push    = vld_p[LAT-1];
    assign pop     = out_valid & out_ready;
    assign pushCls = classify(fma_result);

    // FIFO stage: capture on the edge where the tracked op meets its result
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (issue_valid && !issue_ready) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            resMem[wrPtr] <= fma_result;
            tagMem[wrPtr] <= tag_p[LAT-1];
            clsMem[wrPtr] <= pushCls;
        end
    end

    assign out_valid  = (count != '0);
    assign out_result = out_valid ? resMem[rdPtr] : '0;
    assign out_tag    = out_valid ? tagMem[rdPtr] : '0;
    assign out_class  = out_valid ? clsMem[rdPtr] : 3'd0;

`ifdef FMA_COLLECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (push) begin
            if ((pushCls == 3'd4 || pushCls == 3'd5) && nan_cnt != 16'hFFFF) nan_cnt <= nan_cnt + 1'b1;
            if (pushCls == 3'd3 && inf_cnt != 16'hFFFF) inf_cnt <= inf_cnt + 1'b1;
        end
    end
`endif

    pushNeverFull: assert property (@(posedge clk) disable iff (rst) push |-> (count < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fma_result_collector.sv
// Self-checking bench for fma_result_collector: queue-based reference model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_fma_result_collector;
    localparam int WIDTH = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic [WIDTH-1:0] fma_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_class;
    logic [$clog2(DEPTH):0] count;
    logic             proto_err;
`ifdef FMA_COLLECT_STATS_EN
    logic [15:0]      nan_cnt;
    logic [15:0]      inf_cnt;
`endif

    always #5 clk = ~clk;

    fma_result_collector #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .fma_result(fma_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_class(out_class), .count(count),
`ifdef FMA_COLLECT_STATS_EN
        .nan_cnt(nan_cnt), .inf_cnt(inf_cnt),
`endif
        .proto_err(proto_err)
    );

    typedef struct { logic [TAG_W-1:0] tag; logic [WIDTH-1:0] res; logic [2:0] cls; } ent_t;
    typedef struct { logic [TAG_W-1:0] tag; int due; } pend_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    ent_t  fifoQ[$];
    pend_t pendQ[$];
    bit    modelErr = 0;
    int    modelNan = 0;
    int    modelInf = 0;
    logic [2:0]       popCls[$];
    logic [TAG_W-1:0] popTags[$];
    logic [TAG_W-1:0] accTags[$];
    bit               readyLog[$];

    logic [31:0] specials [8] = '{32'h00000000, 32'h80000001, 32'h7F800000, 32'hFF800000,
                                  32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'h007FFFFF};

    function automatic logic [2:0] refClass(input logic [31:0] w);
        int unsigned e;
        int unsigned fr;
        e  = (w >> 23) & 32'hFF;
        fr = w & 32'h7FFFFF;
        if (e == 0)   return (fr == 0) ? 3'd0 : 3'd1;
        if (e != 255) return 3'd2;
        if (fr == 0)  return 3'd3;
        return (fr >= 32'h400000) ? 3'd4 : 3'd5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare at negedge against the model, then advance the model across the edge
    task automatic step();
        bit    mReady;
        ent_t  e;
        pend_t p;
        @(negedge clk);
        mReady = (fifoQ.size() + pendQ.size()) < DEPTH;
        chk("issue_ready", issue_ready, mReady);
        chk("out_valid", out_valid, fifoQ.size() != 0);
        chk("count", count, fifoQ.size());
        chk("proto_err", proto_err, modelErr);
        if (fifoQ.size() != 0) begin
            chk("out_tag", out_tag, fifoQ[0].tag);
            chk("out_result", out_result, fifoQ[0].res);
            chk("out_class", out_class, fifoQ[0].cls);
        end
`ifdef FMA_COLLECT_STATS_EN
        chk("nan_cnt", nan_cnt, modelNan);
        chk("inf_cnt", inf_cnt, modelInf);
`endif
        if (out_valid && out_ready) begin
            popCls.push_back(out_class);
            popTags.push_back(out_tag);
        end
        if (issue_valid && issue_ready) accTags.push_back(issue_tag);
        readyLog.push_back(issue_ready);
        if (rst) begin
            fifoQ.delete();
            pendQ.delete();
            modelErr = 0;
            modelNan = 0;
            modelInf = 0;
        end else begin
            if (issue_valid && !mReady) modelErr = 1;
            if (out_ready && fifoQ.size() != 0) void'(fifoQ.pop_front());
            if (pendQ.size() != 0 && pendQ[0].due == cyc) begin
                e.tag = pendQ[0].tag;
                e.res = fma_result;
                e.cls = refClass(fma_result);
                fifoQ.push_back(e);
                if ((e.cls == 3'd4 || e.cls == 3'd5) && modelNan < 65535) modelNan++;
                if (e.cls == 3'd3 && modelInf < 65535) modelInf++;
                void'(pendQ.pop_front());
            end
            if (issue_valid && mReady) begin
                p.tag = issue_tag;
                p.due = cyc + LAT;
                pendQ.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            fma_result = $urandom;
            step();
        end
    endtask

    logic [31:0] clsVals [5] = '{32'h00000000, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001};
    logic [2:0]  clsExp  [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
    logic [31:0] statVals[4] = '{32'h7FC00000, 32'h7F800001, 32'hFFC00001, 32'h7F800000};
    logic [2:0]  statExp [4] = '{3'd4, 3'd5, 3'd4, 3'd3};

    initial begin
        logic [7:0] rl;
        rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; fma_result = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        rst = 1'b0;

        // Single op
        issue_valid = 1'b1; issue_tag = 4'd5; fma_result = $urandom; step();
        issue_valid = 1'b0; fma_result = $urandom; step(); step();
        chk("single_early", out_valid, 0);
        fma_result = 32'h41200000; step();
        chk("single_valid", out_valid, 1);
        chk("single_tag", out_tag, 5);
        chk("single_class", out_class, 2);
        chk("single_result", out_result, 32'h41200000);
        out_ready = 1'b1; idle(2);

        // Classes, issued every other cycle and drained immediately
        popCls.delete();
        for (int t = 0; t < 16; t++) begin
            issue_valid = (t % 2 == 0) && (t < 10);
            issue_tag   = TAG_W'(t / 2);
            fma_result  = (t >= 3 && t % 2 == 1 && (t - 3) / 2 < 5) ? clsVals[(t - 3) / 2] : $urandom;
            step();
        end
        chk("class_n", popCls.size(), 5);
        for (int i = 0; i < 5 && i < popCls.size(); i++) chk("class_seq", popCls[i], clsExp[i]);

        // Credits with consumer stalled
        accTags.delete(); popTags.delete(); readyLog.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1; issue_tag = TAG_W'(i); fma_result = $urandom;
            step();
        end
        idle(LAT + 1);
        for (int i = 0; i < 8; i++) rl[i] = readyLog[i];
        chk("credit_ready_pattern", rl, 8'h0F);
        chk("credit_accepted", accTags.size(), 4);
        chk("credit_count", count, 4);
        chk("credit_ready_low", issue_ready, 0);
        chk("proto_set", proto_err, 1);
        idle(3);
        chk("proto_sticky", proto_err, 1);

        // Drain while issuing continues
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue_valid = 1'b1; issue_tag = TAG_W'(8 + i); fma_result = $urandom;
            step();
        end
        idle(10);
        chk("order_n", popTags.size(), accTags.size());
        for (int i = 0; i < popTags.size() && i < accTags.size(); i++) chk("order_tag", popTags[i], accTags[i]);
        for (int i = 0; i < 4 && i < popTags.size(); i++) chk("order_first", popTags[i], TAG_W'(i));

        rst = 1'b1; step(); rst = 1'b0;
        chk("proto_cleared", proto_err, 0);

        // Reset with two ops in the FIFO and two in the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_tag = TAG_W'(i + 1); fma_result = $urandom;
            step();
        end
        idle(1);
        chk("mid_count_pre", count, 2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_count", count, 0);
        chk("mid_issue_ready", issue_ready, 1);
        popTags.delete();
        out_ready = 1'b1; idle(8);
        chk("mid_no_stale", popTags.size(), 0);

        // NaN / inf captures
        popCls.delete();
        for (int t = 0; t < 13; t++) begin
            issue_valid = (t % 2 == 0) && (t < 8);
            issue_tag   = TAG_W'(t);
            fma_result  = (t >= 3 && t % 2 == 1 && (t - 3) / 2 < 4) ? statVals[(t - 3) / 2] : 32'h3F800000;
            step();
        end
        chk("stat_n", popCls.size(), 4);
        for (int i = 0; i < 4 && i < popCls.size(); i++) chk("stat_cls", popCls[i], statExp[i]);
`ifdef FMA_COLLECT_STATS_EN
        chk("stat_nan", nan_cnt, 3);
        chk("stat_inf", inf_cnt, 1);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(99) == 0);
            issue_valid = ($urandom_range(99) < 60);
            issue_tag   = TAG_W'($urandom);
            out_ready   = ($urandom_range(99) < 50);
            fma_result  = ($urandom_range(2) == 0) ? specials[$urandom_range(7)] : $urandom;
            step();
        end
        rst = 1'b0; out_ready = 1'b1; idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
